// File: rtl/uart_regfile_dumper_if.sv
// ---------------------------------------------------------------------------
// uart_regfile_dumper_if
//
// Purpose:
//   Groups the request, register-file read port and UART line signals of the
//   register-file dumper into one bundle.
//
// Signals:
//   start  host -> dumper    dump request, honoured only while idle
//   ra     dumper -> regfile read address (AW bits)
//   rd     regfile -> dumper read data for ra, combinational (DW bits)
//   txd    dumper -> line    8N1 serial output, idle high
//   busy   dumper -> host    high while a dump is in progress
//   done   dumper -> host    one-cycle pulse after the final stop bit
//
// Modports:
//   slave  : the dumper itself (consumes start/rd, produces ra/txd/busy/done)
//   master : the surrounding system (host request + register-file read data)
// ---------------------------------------------------------------------------
interface uart_regfile_dumper_if #(
    parameter int AW = 3,
    parameter int DW = 8
);
    logic          start;
    logic [AW-1:0] ra;
    logic [DW-1:0] rd;
    logic          txd;
    logic          busy;
    logic          done;

    modport master (
        output start,
        output rd,
        input  ra,
        input  txd,
        input  busy,
        input  done
    );

    modport slave (
        input  start,
        input  rd,
        output ra,
        output txd,
        output busy,
        output done
    );
endinterface

// File: rtl/uart_regfile_dumper.sv
// ---------------------------------------------------------------------------
// uart_regfile_dumper
//
// Purpose:
//   On a start request, walks register-file entries 0..NREGS-1 through a
//   combinational read port and sends each one as an 8N1 UART byte (LSB
//   first). Lets a host observe register contents written from the switches.
//
// Ports:
//   clk      in   system clock
//   reset_n  in   asynchronous, active-low reset
//   bus      slave modport of uart_regfile_dumper_if:
//              start (in), rd (in), ra (out), txd (out), busy (out), done (out)
//
// Parameters:
//   CLK_HZ   input clock frequency in Hz
//   BAUD     serial bit rate; CLKS_PER_BIT = CLK_HZ/BAUD (truncated), >= 2
//   NREGS    number of registers dumped, starting at index 0
//   AW       read-address width, NREGS <= 2**AW
//   DW       register data width, only 8 is supported
//
// Build option:
//   DUMP_HEADER_EN  when defined, a constant 0xA5 header frame is sent before
//                   register 0 (no LOAD cycle for it, ra stays 0).
//
// Timing (per byte): 1 LOAD cycle + 10 bit periods of CLKS_PER_BIT cycles.
// Whole dump: NREGS*(1+10*CLKS_PER_BIT)+1 cycles from the accepting edge to
// the done pulse (plus 10*CLKS_PER_BIT with the header enabled).
// ---------------------------------------------------------------------------
module uart_regfile_dumper #(
    parameter int CLK_HZ = 50000000,
    parameter int BAUD   = 115200,
    parameter int NREGS  = 8,
    parameter int AW     = 3,
    parameter int DW     = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    uart_regfile_dumper_if.slave bus
);

    localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
    // Counter must at least hold CLKS_PER_BIT-1; keep one bit minimum.
    localparam int BCW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

    localparam logic [BCW-1:0] BAUD_RELOAD = BCW'(CLKS_PER_BIT - 1);
    localparam logic [AW-1:0]  LAST_IDX    = AW'(NREGS - 1);

`ifdef DUMP_HEADER_EN
    localparam logic [DW-1:0]  HDR_BYTE    = DW'(8'hA5);
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_DATA,
        S_STOP,
        S_FIN
    } state_t;

    state_t         r_state;
    logic [AW-1:0]  r_idx;
    logic [2:0]     r_bit;
    logic [BCW-1:0] r_baud;
    logic           r_txd;
    logic           r_busy;
    logic           r_done;
    logic [DW-1:0]  r_shift;
`ifdef DUMP_HEADER_EN
    logic           r_hdr;
`endif

    logic           w_bit_end;

    // Last cycle of the current bit period.
    assign w_bit_end = (r_baud == '0);

    // Every output comes straight from a flop, so txd cannot glitch.
    assign bus.ra   = r_idx;
    assign bus.txd  = r_txd;
    assign bus.busy = r_busy;
    assign bus.done = r_done;

    // -----------------------------------------------------------------------
    // Control FSM: sequencing, bit timing and all registered outputs.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_bit   <= '0;
            r_baud  <= '0;
            r_txd   <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
`ifdef DUMP_HEADER_EN
            r_hdr   <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_txd  <= 1'b1;
                    r_busy <= 1'b0;
                    r_idx  <= '0;
                    r_bit  <= '0;
                    if (bus.start) begin
                        r_busy <= 1'b1;
`ifdef DUMP_HEADER_EN
                        // Header byte is a constant: skip LOAD, start bit now.
                        r_hdr   <= 1'b1;
                        r_state <= S_START;
                        r_txd   <= 1'b0;
                        r_baud  <= BAUD_RELOAD;
`else
                        r_state <= S_LOAD;
`endif
                    end
                end

                S_LOAD: begin
                    // rd is captured into the shifter on this same edge.
                    r_state <= S_START;
                    r_txd   <= 1'b0;
                    r_baud  <= BAUD_RELOAD;
                end

                S_START: begin
                    if (w_bit_end) begin
                        r_state <= S_DATA;
                        r_txd   <= r_shift[0];
                        r_bit   <= '0;
                        r_baud  <= BAUD_RELOAD;
                    end else begin
                        r_baud  <= r_baud - BCW'(1);
                    end
                end

                S_DATA: begin
                    if (w_bit_end) begin
                        r_baud <= BAUD_RELOAD;
                        if (r_bit == 3'd7) begin
                            r_state <= S_STOP;
                            r_txd   <= 1'b1;
                        end else begin
                            r_bit <= r_bit + 3'd1;
                            // Shifter moves right on this edge, so the next
                            // bit is still at position 1.
                            r_txd <= r_shift[1];
                        end
                    end else begin
                        r_baud <= r_baud - BCW'(1);
                    end
                end

                S_STOP: begin
                    if (w_bit_end) begin
`ifdef DUMP_HEADER_EN
                        if (r_hdr) begin
                            r_hdr   <= 1'b0;
                            r_state <= S_LOAD;
                        end else
`endif
                        if (r_idx == LAST_IDX) begin
                            r_state <= S_FIN;
                            r_done  <= 1'b1;
                        end else begin
                            r_idx   <= r_idx + AW'(1);
                            r_state <= S_LOAD;
                        end
                    end else begin
                        r_baud <= r_baud - BCW'(1);
                    end
                end

                S_FIN: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_idx   <= '0;
                    r_txd   <= 1'b1;
                end

                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_idx   <= '0;
                    r_txd   <= 1'b1;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Data shifter: holds the byte in flight, independent of later regfile
    // writes. Pure datapath, so it carries no reset.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (r_state == S_LOAD) begin
            r_shift <= bus.rd;
`ifdef DUMP_HEADER_EN
        end else if (r_state == S_IDLE && bus.start) begin
            r_shift <= HDR_BYTE;
`endif
        end else if (r_state == S_DATA && w_bit_end) begin
            r_shift <= {1'b0, r_shift[DW-1:1]};
        end
    end

endmodule

// File: doc/uart_regfile_dumper.md
Name: uart_regfile_dumper

Overview:
- Reader-side companion to the switch-driven register-file write path in Mod_Test.
- On a start pulse, reads each register-file entry through a read-address port and transmits it as one 8N1 UART byte on UART_TXD.
- Lets a host observe register contents that were written via SW[17:14]/SW[7:0].
- Sits between the register file's second read port and UART_TXD. Register-file read is combinational: ra in, rd out in the same cycle.

Parameters:
- CLK_HZ, 50000000, input clock frequency in Hz.
- BAUD, 115200, serial bit rate. CLKS_PER_BIT = CLK_HZ/BAUD, integer truncation, must be >= 2.
- NREGS, 8, number of registers dumped, starting at index 0.
- AW, 3, read-address width; NREGS <= 2**AW.
- DW, 8, register data width; only DW=8 is supported.

Ports:
- clk  in  1  system clock (CLOCK_50 at top level).
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  dump request, sampled on rising clk, honoured only in IDLE.
- ra  out  AW  register-file read address.
- rd  in  DW  register-file read data for ra, combinational.
- txd  out  1  UART serial output, idle high.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse after the final stop bit.

Behaviour:
- Reset (reset_n=0, async, takes effect immediately even mid-frame):
  - txd=1, busy=0, done=0, ra=0.
  - state=IDLE, byte index=0, bit counter=0, baud counter=0.
- States: IDLE -> LOAD -> START -> DATA -> STOP -> (LOAD | FIN) -> IDLE.
- IDLE:
  - txd=1, busy=0.
  - start=1 -> LOAD with index=0. start=0 -> stay in IDLE.
- LOAD (exactly 1 cycle):
  - ra=index.
  - At the clock edge, shift register <= rd. Later changes to register-file contents do not affect the byte in flight.
  - Then go to START.
- START: txd=0 for CLKS_PER_BIT cycles.
- DATA:
  - 8 bits, LSB first, each held CLKS_PER_BIT cycles.
  - Bit counter counts 0..7.
- STOP:
  - txd=1 for CLKS_PER_BIT cycles.
  - Then, if index==NREGS-1 -> FIN; else index+1 -> LOAD.
- FIN (1 cycle): done=1, busy still 1. Next cycle: IDLE, busy=0, ra=0.
- Timing:
  - Per byte: 1 + 10*CLKS_PER_BIT cycles.
  - Whole dump: NREGS*(1+10*CLKS_PER_BIT) + 1 cycles from the start-accept edge to the done pulse.
- Baud counter:
  - Loads CLKS_PER_BIT-1 on entry to each bit and counts down to 0.
  - Bit transition happens on the 0 count.
  - No fractional-baud correction.
- Boundary conditions:
  - start while busy: ignored, not queued.
  - start held high continuously: a new dump begins in the cycle after returning to IDLE (back-to-back dumps allowed).
  - ra holds the last index between LOAD cycles and returns to 0 in IDLE.
  - Register 0 is transmitted exactly as rd reports it; no forced zero.
  - txd is driven directly from a flop, never from combinational logic, so there are no glitches.

Optional Feature:
- Macro DUMP_HEADER_EN.
- Defined:
  - A header frame of 0xA5 is sent before register 0.
  - Sequence: IDLE -> HDR-frame (START/DATA/STOP with constant 0xA5, no LOAD cycle) -> LOAD(index 0) ...
  - Total cycles = 10*CLKS_PER_BIT + NREGS*(1+10*CLKS_PER_BIT) + 1.
  - ra=0 during the header frame.
- Undefined: no header; behaviour exactly as above.

Test Plan (CLK_HZ=50000000, BAUD=5000000 -> CLKS_PER_BIT=10, frame=100 cycles, dump=809 cycles):
- Reset: assert reset_n=0 mid-simulation -> txd=1, busy=0, done=0, ra=0 immediately, before the next clk edge.
- Basic dump:
  - Stimulus: write $1=0xCA, $7=0xFE, $0=0xDB, others 0x00; pulse start for 1 cycle.
  - Expected bytes on txd: DB,CA,00,00,00,00,00,FE, LSB first, each bit exactly 10 cycles.
  - busy=1 for 809 cycles; done pulses once on cycle 809; ra steps 0..7.
- Capture isolation: overwrite $1 with 0x11 during byte 1's DATA phase -> byte 1 still CA. A second dump sends 11.
- Start while busy: pulse start again at cycle 300 -> ignored; exactly 8 frames and one done pulse.
- Mid-frame reset: drop reset_n during byte 3's DATA phase -> txd=1 and busy=0 at once. A new start after release sends the full sequence from register 0.
- Header (DUMP_HEADER_EN defined): start -> frames A5,DB,CA,00,00,00,00,00,FE; done on cycle 909.
